// File: rtl/mailbox_irq_arbiter_if.sv
// Signal bundle between the mailbox channel array, the interrupt arbiter and
// the destination core's interrupt input.
interface mailbox_irq_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
);
    logic [NUM_CH-1:0]    int_flag;
    logic [32*NUM_CH-1:0] ch_ctrl_bus;
    logic [NUM_CH-1:0]    irq_mask;
    logic                 irq_ack;
    logic                 timeout_clr;

    logic                 irq;
    logic [ID_W-1:0]      irq_id;
    logic [1:0]           irq_mode;
    logic [13:0]          irq_len;
    logic [NUM_CH-1:0]    clear_intr;
    logic                 irq_timeout;
    logic                 busy;

    // The arbiter is the slave of the channel/core side; the environment drives it.
    modport slave (
        input  int_flag,
        input  ch_ctrl_bus,
        input  irq_mask,
        input  irq_ack,
        input  timeout_clr,
        output irq,
        output irq_id,
        output irq_mode,
        output irq_len,
        output clear_intr,
        output irq_timeout,
        output busy
    );

    modport master (
        output int_flag,
        output ch_ctrl_bus,
        output irq_mask,
        output irq_ack,
        output timeout_clr,
        input  irq,
        input  irq_id,
        input  irq_mode,
        input  irq_len,
        input  clear_intr,
        input  irq_timeout,
        input  busy
    );
endinterface

// File: rtl/mailbox_irq_arbiter.sv
// Round-robin interrupt arbiter for the mailbox channel array: one interrupt at
// a time, cleared on acknowledge, with a guard cycle before the next grant.
module mailbox_irq_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    mailbox_irq_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        CLEAR,
        DROP
    } state_t;

    localparam logic [15:0] TIMEOUT_MAX  = 16'(TIMEOUT);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic [1:0]        irq_mode_q, irq_mode_d;
    logic [13:0]       irq_len_q, irq_len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic [NUM_CH-1:0] clear_q, clear_d;
    logic              irq_q, irq_d;
    logic              busy_q, busy_d;

    logic [NUM_CH-1:0] req;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   probe_id;

    logic [1:0]        ctrl_mode [NUM_CH];
    logic [13:0]       ctrl_len  [NUM_CH];

    // Only the mode and length fields of each ch_ctrl word matter here.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ctrl
        logic unused_ctrl;
        assign ctrl_mode[g] = bus.ch_ctrl_bus[32*g+29 +: 2];
        assign ctrl_len[g]  = bus.ch_ctrl_bus[32*g+15 +: 14];
        assign unused_ctrl  = ^{bus.ch_ctrl_bus[32*g+31], bus.ch_ctrl_bus[32*g +: 15]};
    end

    assign req = bus.int_flag & bus.irq_mask;

    // Search upward from the channel after the last grant, wrapping at NUM_CH.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        probe_id    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            probe_id = ID_W'((int'(last_id_q) + i) % NUM_CH);
            if (!grant_found && req[probe_id]) begin
                grant_found = 1'b1;
                grant_id    = probe_id;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        irq_id_d   = irq_id_q;
        irq_mode_d = irq_mode_q;
        irq_len_d  = irq_len_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        clear_d    = '0;

        if (bus.timeout_clr) begin
            timeout_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d    = ASSERT;
                    irq_id_d   = grant_id;
                    last_id_d  = grant_id;
                    irq_mode_d = ctrl_mode[grant_id];
                    irq_len_d  = ctrl_len[grant_id];
                    cnt_d      = '0;
                end
            end
            ASSERT: begin
                if (cnt_q != TIMEOUT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Setting after the clear above makes a coincident set win.
                if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                end
                if (bus.irq_ack) begin
                    state_d           = CLEAR;
                    clear_d[irq_id_q] = 1'b1;
                end else if (!bus.int_flag[irq_id_q]) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d = DROP;
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        irq_d  = (state_d == ASSERT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_id_q  <= ID_W'(NUM_CH - 1);
            irq_id_q   <= '0;
            irq_mode_q <= '0;
            irq_len_q  <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            clear_q    <= '0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            irq_id_q   <= irq_id_d;
            irq_mode_q <= irq_mode_d;
            irq_len_q  <= irq_len_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
            clear_q    <= clear_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.irq         = irq_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.irq_mode    = irq_mode_q;
    assign bus.irq_len     = irq_len_q;
    assign bus.clear_intr  = clear_q;
    assign bus.irq_timeout = timeout_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mailbox_irq_arbiter.sv
// Directed bench for mailbox_irq_arbiter: four channels, TIMEOUT shortened to 8.
module tb_mailbox_irq_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mailbox_irq_arbiter_if #(.NUM_CH(4), .ID_W(2)) bus ();

    mailbox_irq_arbiter #(.NUM_CH(4), .ID_W(2), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.int_flag    = '0;
        bus.ch_ctrl_bus = '0;
        bus.irq_mask    = 4'hF;
        bus.irq_ack     = 1'b0;
        bus.timeout_clr = 1'b0;
        do_reset();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %0h want 0", bus.irq); end
        checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id: got %0h want 0", bus.irq_id); end
        checks++; if (bus.irq_mode !== 2'd0) begin errors++; $display("[TB] FAIL reset_mode: got %0h want 0", bus.irq_mode); end
        checks++; if (bus.irq_len !== 14'd0) begin errors++; $display("[TB] FAIL reset_len: got %0h want 0", bus.irq_len); end
        checks++; if (bus.clear_intr !== 4'd0) begin errors++; $display("[TB] FAIL reset_clear: got %0h want 0", bus.clear_intr); end
        checks++; if (bus.irq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0h want 0", bus.irq_timeout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h want 0", bus.busy); end
    endtask

    task automatic test_single_request();
        bus.ch_ctrl_bus[64 +: 32] = 32'hA000_8000;
        bus.int_flag = 4'b0100;
        tick();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("[TB] FAIL single_irq: got %0h want 1", bus.irq); end
        checks++; if (bus.irq_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id: got %0h want 2", bus.irq_id); end
        checks++; if (bus.irq_mode !== 2'b01) begin errors++; $display("[TB] FAIL single_mode: got %0h want 1", bus.irq_mode); end
        checks++; if (bus.irq_len !== 14'h0001) begin errors++; $display("[TB] FAIL single_len: got %0h want 1", bus.irq_len); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %0h want 1", bus.busy); end
        // Rewriting ctrl and mask after grant must not disturb the latched grant
        bus.ch_ctrl_bus[64 +: 32] = 32'h0;
        bus.irq_mask = 4'h0;
        bus.irq_ack  = 1'b1;
        tick();
        bus.irq_ack  = 1'b0;
        checks++; if (bus.clear_intr !== 4'b0100) begin errors++; $display("[TB] FAIL single_clear: got %0h want 4", bus.clear_intr); end
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL single_irq_low: got %0h want 0", bus.irq); end
        checks++; if (bus.irq_mode !== 2'b01) begin errors++; $display("[TB] FAIL single_mode_hold: got %0h want 1", bus.irq_mode); end
        checks++; if (bus.irq_len !== 14'h0001) begin errors++; $display("[TB] FAIL single_len_hold: got %0h want 1", bus.irq_len); end
        bus.int_flag = 4'b0000;
        bus.ch_ctrl_bus[64 +: 32] = 32'hA000_8000;
        bus.irq_mask = 4'hF;
        tick();
        checks++; if (bus.clear_intr !== 4'b0000) begin errors++; $display("[TB] FAIL single_clear_once: got %0h want 0", bus.clear_intr); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_drop_busy: got %0h want 1", bus.busy); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %0h want 0", bus.busy); end
        checks++; if (bus.irq_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id_hold: got %0h want 2", bus.irq_id); end
    endtask

    task automatic test_round_robin();
        logic [1:0] rr_exp [5];
        logic [3:0] clr_exp;
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bus.int_flag = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.irq !== 1'b1) begin errors++; $display("[TB] FAIL rr_irq[%0d]: got %0h want 1", k, bus.irq); end
            checks++; if (bus.irq_id !== rr_exp[k]) begin errors++; $display("[TB] FAIL rr_id[%0d]: got %0h want %0h", k, bus.irq_id, rr_exp[k]); end
            bus.irq_ack = 1'b1;
            tick();
            bus.irq_ack = 1'b0;
            clr_exp = 4'b0001 << rr_exp[k];
            checks++; if (bus.clear_intr !== clr_exp) begin errors++; $display("[TB] FAIL rr_clear[%0d]: got %0h want %0h", k, bus.clear_intr, clr_exp); end
            tick();
            tick();
        end
        bus.int_flag = 4'h0;
    endtask

    task automatic test_mask();
        bus.int_flag = 4'b1010;
        bus.irq_mask = 4'b0010;
        tick();
        checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("[TB] FAIL mask_id: got %0h want 1", bus.irq_id); end
        bus.irq_mask = 4'b0000;
        tick();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("[TB] FAIL mask_hold_irq: got %0h want 1", bus.irq); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        checks++; if (bus.clear_intr !== 4'b0010) begin errors++; $display("[TB] FAIL mask_clear: got %0h want 2", bus.clear_intr); end
        tick();
        tick();
        bus.irq_mask = 4'hF;
        tick();
        checks++; if (bus.irq_id !== 2'd3) begin errors++; $display("[TB] FAIL mask_next_id: got %0h want 3", bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack  = 1'b0;
        bus.int_flag = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bus.int_flag = 4'b0001;
        tick();
        checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("[TB] FAIL to_id: got %0h want 0", bus.irq_id); end
        for (int k = 0; k < 7; k++) tick();
        checks++; if (bus.irq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_early: got %0h want 0", bus.irq_timeout); end
        tick();
        checks++; if (bus.irq_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_set: got %0h want 1", bus.irq_timeout); end
        tick();
        tick();
        checks++; if (bus.irq !== 1'b1) begin errors++; $display("[TB] FAIL to_irq_hold: got %0h want 1", bus.irq); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack  = 1'b0;
        bus.int_flag = 4'b0000;
        checks++; if (bus.clear_intr !== 4'b0001) begin errors++; $display("[TB] FAIL to_clear: got %0h want 1", bus.clear_intr); end
        checks++; if (bus.irq_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: got %0h want 1", bus.irq_timeout); end
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        checks++; if (bus.irq_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_cleared: got %0h want 0", bus.irq_timeout); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: got %0h want 0", bus.busy); end
    endtask

    task automatic test_spurious_drop();
        bus.int_flag = 4'b0010;
        tick();
        checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("[TB] FAIL sp_id: got %0h want 1", bus.irq_id); end
        bus.int_flag = 4'b0000;
        tick();
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL sp_irq: got %0h want 0", bus.irq); end
        checks++; if (bus.clear_intr !== 4'b0000) begin errors++; $display("[TB] FAIL sp_clear: got %0h want 0", bus.clear_intr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sp_busy: got %0h want 0", bus.busy); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        checks++; if (bus.clear_intr !== 4'b0000) begin errors++; $display("[TB] FAIL sp_idle_ack_clear: got %0h want 0", bus.clear_intr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sp_idle_ack_busy: got %0h want 0", bus.busy); end
        checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("[TB] FAIL sp_id_hold: got %0h want 1", bus.irq_id); end
    endtask

    task automatic test_reset_mid();
        bus.ch_ctrl_bus[32 +: 32] = 32'h4003_0000;
        bus.int_flag = 4'b0110;
        tick();
        checks++; if (bus.irq_id !== 2'd2) begin errors++; $display("[TB] FAIL rm_id: got %0h want 2", bus.irq_id); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        checks++; if (bus.clear_intr !== 4'b0100) begin errors++; $display("[TB] FAIL rm_clear: got %0h want 4", bus.clear_intr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.irq !== 1'b0) begin errors++; $display("[TB] FAIL rm_irq: got %0h want 0", bus.irq); end
        checks++; if (bus.irq_id !== 2'd0) begin errors++; $display("[TB] FAIL rm_id_zero: got %0h want 0", bus.irq_id); end
        checks++; if (bus.irq_len !== 14'd0) begin errors++; $display("[TB] FAIL rm_len_zero: got %0h want 0", bus.irq_len); end
        checks++; if (bus.clear_intr !== 4'd0) begin errors++; $display("[TB] FAIL rm_clear_zero: got %0h want 0", bus.clear_intr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_busy: got %0h want 0", bus.busy); end
        tick();
        checks++; if (bus.irq_id !== 2'd1) begin errors++; $display("[TB] FAIL rm_next_id: got %0h want 1", bus.irq_id); end
        checks++; if (bus.irq_mode !== 2'b10) begin errors++; $display("[TB] FAIL rm_next_mode: got %0h want 2", bus.irq_mode); end
        checks++; if (bus.irq_len !== 14'h0006) begin errors++; $display("[TB] FAIL rm_next_len: got %0h want 6", bus.irq_len); end
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack  = 1'b0;
        bus.int_flag = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_round_robin();
        test_mask();
        test_timeout();
        test_spurious_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
